// File: rtl/twp_pkg.sv
// Shared definitions for the two-wire protocol master and the TPA slave.
package twp_pkg;

  localparam int TWP_ADDR_BITS = 8;
  localparam int TWP_DATA_BITS = 16;
  localparam int TWP_CNT_BITS  = 4;

  localparam logic TWP_CMD_WRITE = 1'b1;
  localparam logic TWP_CMD_READ  = 1'b0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_TURN,
    ST_WAIT_START,
    ST_RDATA,
    ST_GAP
  } twp_state_t;

endpackage

// File: rtl/twp_shift16.sv
// 16-bit shift register used for both write serialization and read capture.
// Shifts right: bit 0 leaves first, the new bit enters at the MSB.
module twp_shift16
  import twp_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     load,
  input  logic [TWP_DATA_BITS-1:0] load_data,
  input  logic                     shift,
  input  logic                     shift_in,
  output logic [TWP_DATA_BITS-1:0] data,
  output logic [TWP_CNT_BITS-1:0]  count
);

  // load takes priority; count tracks the number of shifts since the last load
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data  <= '0;
      count <= '0;
    end else if (load) begin
      data  <= load_data;
      count <= '0;
    end else if (shift) begin
      data  <= {shift_in, data[TWP_DATA_BITS-1:1]};
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/twp_master.sv
// Two-wire protocol master: serializes single register requests onto sda
// and, for reads, waits for the slave start bit and captures 16 data bits.
//
// state         | meaning
// ST_IDLE       | bus released, req_ready high
// ST_START      | drive start bit (0)
// ST_CMD        | drive command bit
// ST_ADDR       | drive address, LSB first
// ST_WDATA      | drive write data, LSB first
// ST_TURN       | release bus, arm timeout
// ST_WAIT_START | bus released, wait for slave start bit or timeout
// ST_RDATA      | capture read data, LSB first
// ST_GAP        | drive idle-high; response pulse in last cycle
module twp_master
  import twp_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned GAP     = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_cmd,
  input  logic [TWP_ADDR_BITS-1:0] req_addr,
  input  logic [TWP_DATA_BITS-1:0] req_wdata,
  output logic                     rsp_valid,
  output logic [TWP_DATA_BITS-1:0] rsp_rdata,
  output logic                     rsp_err,
  output logic                     scl,
  inout  wire                      sda
);

  localparam int TMR_W = 16;
  localparam logic [TWP_CNT_BITS-1:0] LAST_BIT = TWP_CNT_BITS'(TWP_DATA_BITS - 1);

  twp_state_t               state;
  logic                     cmd_q;
  logic [TWP_ADDR_BITS-1:0] addr_q;
  logic [TWP_CNT_BITS-1:0]  bit_cnt;
  logic [TMR_W-1:0]         tmr;
  logic                     err_q;
  logic                     sda_oe;
  logic                     sda_out;

  logic                     sh_load;
  logic [TWP_DATA_BITS-1:0] sh_load_data;
  logic                     sh_shift;
  logic [TWP_DATA_BITS-1:0] sh_data;
  logic [TWP_CNT_BITS-1:0]  sh_count;

  assign sda = sda_oe ? sda_out : 1'bz;

  // shift register control: reads start from a cleared register
  always_comb begin
    sh_load      = req_valid & req_ready;
    sh_load_data = (req_cmd == TWP_CMD_WRITE) ? req_wdata : '0;
    sh_shift     = (state == ST_WDATA) || (state == ST_RDATA);
  end

  twp_shift16 u_shift (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (sh_load),
    .load_data (sh_load_data),
    .shift     (sh_shift),
    .shift_in  (sda),
    .data      (sh_data),
    .count     (sh_count)
  );

  // protocol FSM; every output is set for the state being entered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      scl       <= 1'b1;
      sda_oe    <= 1'b0;
      sda_out   <= 1'b1;
      cmd_q     <= 1'b0;
      addr_q    <= '0;
      bit_cnt   <= '0;
      tmr       <= '0;
      err_q     <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            state     <= ST_START;
            req_ready <= 1'b0;
            cmd_q     <= req_cmd;
            addr_q    <= req_addr;
            err_q     <= 1'b0;
            scl       <= 1'b0;
            sda_oe    <= 1'b1;
            sda_out   <= 1'b0;
          end
        end
        ST_START: begin
          state   <= ST_CMD;
          sda_out <= cmd_q;
        end
        ST_CMD: begin
          state   <= ST_ADDR;
          sda_out <= addr_q[0];
          addr_q  <= addr_q >> 1;
          bit_cnt <= '0;
        end
        ST_ADDR: begin
          if (bit_cnt == TWP_CNT_BITS'(TWP_ADDR_BITS - 1)) begin
            if (cmd_q == TWP_CMD_WRITE) begin
              state   <= ST_WDATA;
              sda_out <= sh_data[0];
            end else begin
              state  <= ST_TURN;
              sda_oe <= 1'b0;
            end
          end else begin
            sda_out <= addr_q[0];
            addr_q  <= addr_q >> 1;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_WDATA: begin
          // the register shifts this edge, so the next bit is at data[1]
          if (sh_count == LAST_BIT) begin
            state   <= ST_GAP;
            sda_out <= 1'b1;
            scl     <= 1'b1;
            tmr     <= TMR_W'(GAP - 1);
          end else begin
            sda_out <= sh_data[1];
          end
        end
        ST_TURN: begin
          state <= ST_WAIT_START;
          tmr   <= TMR_W'(TIMEOUT - 1);
        end
        ST_WAIT_START: begin
          if (sda == 1'b0) begin
            state <= ST_RDATA;
          end else if (tmr == '0) begin
            state   <= ST_GAP;
            err_q   <= 1'b1;
            scl     <= 1'b1;
            sda_oe  <= 1'b1;
            sda_out <= 1'b1;
            tmr     <= TMR_W'(GAP - 1);
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        ST_RDATA: begin
          if (sh_count == LAST_BIT) begin
            state   <= ST_GAP;
            scl     <= 1'b1;
            sda_oe  <= 1'b1;
            sda_out <= 1'b1;
            tmr     <= TMR_W'(GAP - 1);
          end
        end
        ST_GAP: begin
          if (tmr == TMR_W'(1)) begin
            rsp_valid <= 1'b1;
            rsp_err   <= err_q;
            rsp_rdata <= (err_q || cmd_q == TWP_CMD_WRITE) ? '0 : sh_data;
          end
          if (tmr == '0) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            sda_oe    <= 1'b0;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/twp_master.md
# twp_master

Two-wire protocol (TWP) master that sits directly upstream of the TPA register block. It accepts single register read/write requests on a valid/ready interface, serializes them onto the shared SDA line (start, command, address, write data), and for reads releases the bus, waits for the slave's start bit and deserializes the 16-bit read data. Each request completes with a one-cycle response pulse carrying read data or a timeout error.

## Interface
- TIMEOUT, 16: max cycles to wait for the slave's read start bit after turnaround (≥ 8).
- GAP, 2: bus-idle cycles (SDA driven high) after each transaction before the next may start (≥ 2).
- clk  input  1  clock; all logic on rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  high only in IDLE; the transfer occurs on req_valid & req_ready.
- req_cmd  input  1  1 = write, 0 = read.
- req_addr  input  8  register address.
- req_wdata  input  16  write data; ignored for reads.
- rsp_valid  output  1  one-cycle pulse at transaction end.
- rsp_rdata  output  16  read data; holds its value until the next response. 0 on write and on error.
- rsp_err  output  1  read timeout flag; qualified by rsp_valid.
- scl  output  1  frame indicator: 0 from START through the last data cycle, otherwise 1.
- sda  inout  1  serial data line; the bus has an external pull-up.

## Operation
- States: IDLE, START, CMD, ADDR, WDATA, TURN, WAIT_START, RDATA, GAP.
- IDLE: sda released. On handshake, latch cmd/addr/wdata and go to START.
- START (1 cycle): drive sda=0.
- CMD (1 cycle): drive sda=cmd.
- ADDR (8 cycles): drive addr[0]..addr[7], LSB first, using a 4-bit bit counter.
- WDATA (write only, 16 cycles): drive wdata[0]..wdata[15], LSB first, then go to GAP.
- TURN (read, 1 cycle): release sda. Clear the timeout counter.
- WAIT_START: sda released.
  - Sampled sda==0 → RDATA.
  - Timeout counter reaches TIMEOUT-1 → set rsp_err=1, rsp_rdata=0, then GAP.
- RDATA (16 cycles): sample sda into rdata[0]..rdata[15], LSB first. After bit 15, go to GAP.
- GAP (GAP cycles): drive sda=1. rsp_valid=1 in the final GAP cycle, then IDLE.
- sda drive rule: the output enable is active only in START, CMD, ADDR, WDATA and GAP. In all other states sda is high-Z.
- Sampling rule: sda is compared with `== 1'b0`. X or Z is never treated as a start bit.
- Reset mid-transaction: all state is cleared immediately and sda is released. No response is generated for the aborted request.

## Timing
- Reset values:
  - req_ready=1 after reset release (IDLE).
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - scl=1, sda high-Z.
- Handshake at edge T: START occupies cycle T+1, CMD occupies T+2, ADDR occupies T+3..T+10.
- Write: WDATA occupies T+11..T+26, GAP occupies T+27..T+28. rsp_valid is high in T+28, and req_ready is high again in T+29.
- Read against TPA:
  - Slave start bit is on the bus in T+14. Data bits are in T+15..T+30.
  - GAP occupies T+31..T+32; rsp_valid is high in T+32.
- Back-to-back requests: req_valid held high is accepted on the first cycle in IDLE. Minimum spacing is 29 cycles for writes.
- req_* inputs are sampled only at the handshake edge. Later changes have no effect on a transaction in flight.

## Structure
- Shared package twp_pkg holds:
  - state enum (twp_state_t);
  - TWP_ADDR_BITS=8 and TWP_DATA_BITS=16;
  - TWP_CMD_WRITE=1 and TWP_CMD_READ=0.
- The TPA slave imports the same package.
- One sub-module, twp_shift16: a 16-bit shift register with load, shift-out LSB, shift-in MSB and bit count. It serves both WDATA and RDATA.
- The FSM, timeout counter and tristate control stay in twp_master.

## Test plan
- Write: cmd=1, addr=8'h3C, wdata=16'hA55A into the TPA model → rsp_valid at T+28 with rsp_err=0; a subsequent TPA config-port read of 8'h3C returns 16'hA55A.
- Read: preload TPA reg 8'h81=16'h1234; read addr=8'h81 → rsp_valid at T+32 with rsp_rdata=16'h1234 and rsp_err=0.
- Timeout: read with the slave absent (pull-up only) → rsp_valid at T+11+TIMEOUT+GAP with rsp_err=1 and rsp_rdata=0.
- Back-to-back: write 8'h00=16'hFFFF immediately followed by read 8'h00 → second handshake exactly at T+29; read returns 16'hFFFF.
- Reset mid-op: assert reset_n low during ADDR bit 4 → sda high-Z and scl=1 within the same cycle; no rsp_valid; TPA returns to idle and a fresh write succeeds.
- Bus checker throughout all tests: the master never drives sda in TURN, WAIT_START or RDATA, and no X is ever driven.
